sram_arb: RTL

- Two-port arbiter that shares the single SRAM core issue interface of the SRAM controller/IO top between two requesters.
- Port 0 is the CPU and port 1 is video/DMA.
- Selects one request per cycle: round-robin by default, fixed priority optional.
- Tracks the issuing port of every read in an in-order tag FIFO and steers returned read-data-valid back to that port.
- Sits between the requesters and the sram_req/sram_ready/sram_rd_data_vld interface.

---
 rtl/sram_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/sram_arb.sv
// Two-port SRAM issue arbiter (RR or fixed prio) with in-order read-tag FIFO for return steering.
// Zero-latency combinational issue path; mN_ready follows sram_ready; reads stall on full tag FIFO.
module sram_arb #(
   parameter int TAG_DEPTH  = 4,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        m0_req,
   output logic        m0_ready,
   input  logic        m0_rd,
   input  logic [17:0] m0_addr,
   input  logic [1:0]  m0_be,
   input  logic [15:0] m0_wr_data,
   output logic        m0_rd_data_vld,
   input  logic        m1_req,
   output logic        m1_ready,
   input  logic        m1_rd,
   input  logic [17:0] m1_addr,
   input  logic [1:0]  m1_be,
   input  logic [15:0] m1_wr_data,
   output logic        m1_rd_data_vld,
   output logic [15:0] rd_data,
   output logic        sram_req,
   input  logic        sram_ready,
   output logic        sram_rd,
   output logic [17:0] sram_addr,
   output logic [1:0]  sram_be,
   output logic [15:0] sram_wr_data,
   input  logic        sram_rd_data_vld,
   input  logic [15:0] sram_rd_data,
   output logic        arb_err
);

   localparam int PW = $clog2(TAG_DEPTH);

   typedef struct packed {
      logic        rd;
      logic [17:0] addr;
      logic [1:0]  be;
      logic [15:0] wr_data;
   } req_t;

   logic [PW:0]          r_wr_ptr;
   logic [PW:0]          r_rd_ptr;
   logic [TAG_DEPTH-1:0] r_tags;
   logic                 r_last_grant;
   logic                 r_arb_err;

   logic w_full, w_empty, w_elig0, w_elig1;
   logic w_gnt_vld, w_gnt, w_accept, w_push, w_pop, w_head;
   req_t w_m0, w_m1, w_sel;

   assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   // Full blocks reads only; uses registered full so a same-cycle pop does not help.
   assign w_elig0 = m0_req & (~m0_rd | ~w_full);
   assign w_elig1 = m1_req & (~m1_rd | ~w_full);

   always_comb begin
      w_gnt_vld = w_elig0 | w_elig1;
      w_gnt     = 1'b0;
      if (w_elig0 && w_elig1)
         w_gnt = FIXED_PRIO ? 1'b0 : ~r_last_grant;
      else if (w_elig1)
         w_gnt = 1'b1;
   end

   assign w_m0  = '{rd: m0_rd, addr: m0_addr, be: m0_be, wr_data: m0_wr_data};
   assign w_m1  = '{rd: m1_rd, addr: m1_addr, be: m1_be, wr_data: m1_wr_data};
   assign w_sel = w_gnt ? w_m1 : w_m0;

   assign sram_req     = w_gnt_vld;
   assign sram_rd      = w_sel.rd;
   assign sram_addr    = w_sel.addr;
   assign sram_be      = w_sel.be;
   assign sram_wr_data = w_sel.wr_data;

   assign m0_ready = sram_ready & sram_req & ~w_gnt;
   assign m1_ready = sram_ready & sram_req &  w_gnt;

   assign w_accept = sram_req & sram_ready;
   assign w_push   = w_accept & w_sel.rd;
   assign w_pop    = sram_rd_data_vld & ~w_empty;
   assign w_head   = r_tags[r_rd_ptr[PW-1:0]];

   assign m0_rd_data_vld = w_pop & ~w_head;
   assign m1_rd_data_vld = w_pop &  w_head;
   assign rd_data        = sram_rd_data;
   assign arb_err        = r_arb_err;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_tags       <= '0;
         r_last_grant <= 1'b1;
         r_arb_err    <= 1'b0;
      end else begin
         if (w_accept)
            r_last_grant <= w_gnt;
         if (w_push) begin
            r_tags[r_wr_ptr[PW-1:0]] <= w_gnt;
            r_wr_ptr                 <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (sram_rd_data_vld && w_empty)
            r_arb_err <= 1'b1;
      end
   end

endmodule
